humidity_frame_checker: RTL and testbench

// Downstream consumer of the DHT humidity sensor reader's 40-bit frame (HYM2). Samples the frame a fixed

---
 rtl/humidity_frame_checker.sv | 168 ++++++++++++++++
 tb/tb_humidity_frame_checker.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/humidity_frame_checker.sv
// ----------------------------------------------------------------------------
// humidity_frame_checker: validates DHT frames after each acquisition strobe,
// holds last good RH/T, converts them to BCD and drives the fan with hysteresis.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module humidity_frame_checker #(
  parameter int SAMPLE_DELAY = 25000,
  parameter int RH_ON        = 70,
  parameter int RH_OFF       = 60,
  parameter int FAULT_LIMIT  = 3
) (
  input  logic        clk1M,
  input  logic        rst,
  input  logic        flag_five_sec,
  input  logic [39:0] HYM2,
  output logic [7:0]  rh_int,
  output logic [7:0]  t_int,
  output logic [11:0] rh_bcd,
  output logic [11:0] t_bcd,
  output logic        data_valid,
  output logic        new_sample,
  output logic        crc_err,
  output logic [7:0]  err_cnt,
  output logic        sensor_fault,
  output logic        fan_on
);

  localparam int               C_CW     = $clog2(SAMPLE_DELAY + 1);
  localparam int               C_FW     = $clog2(FAULT_LIMIT + 1);
  localparam logic [C_CW-1:0]  C_DELAY  = C_CW'(SAMPLE_DELAY);
  localparam logic [C_CW-1:0]  C_ONE    = C_CW'(1);
  localparam logic [C_FW-1:0]  C_FAULT  = C_FW'(FAULT_LIMIT);
  localparam logic [7:0]       C_RH_ON  = 8'(RH_ON);
  localparam logic [7:0]       C_RH_OFF = 8'(RH_OFF);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_CHECK  = 3'd2,
    S_BCD    = 3'd3,
    S_UPDATE = 3'd4
  } state_t;

  state_t            r_state;
  logic [2:0]        r_edge_sr;
  logic [C_CW-1:0]   r_cnt;
  logic [2:0]        r_bit;
  logic [7:0]        r_rh_raw;
  logic [7:0]        r_t_raw;
  logic              r_good;
  logic [19:0]       r_rh_sr;
  logic [19:0]       r_t_sr;
  logic [C_FW-1:0]   r_consec;

  logic              w_edge;
  logic [7:0]        w_sum;
  logic              w_good;
  logic [C_FW-1:0]   w_consec_nx;
  logic [19:0]       w_rh_step;
  logic [19:0]       w_t_step;

  // One double-dabble iteration: {bcd[11:0], bin[7:0]} adjusted then shifted left.
  function automatic logic [19:0] dd_step(input logic [19:0] s);
    logic [19:0] a;
    a = s;
    for (int d = 0; d < 3; d++) begin
      if (a[8+4*d +: 4] >= 4'd5) a[8+4*d +: 4] = a[8+4*d +: 4] + 4'd3;
    end
    return {a[18:0], 1'b0};
  endfunction

  assign w_edge      = (r_edge_sr[2:1] == 2'b01);
  assign w_sum       = HYM2[39:32] + HYM2[31:24] + HYM2[23:16] + HYM2[15:8];
  assign w_good      = (w_sum == HYM2[7:0]) && (HYM2 != 40'd0);
  assign w_consec_nx = (r_consec >= C_FAULT) ? C_FAULT : r_consec + 1'b1;
  assign w_rh_step   = dd_step(r_rh_sr);
  assign w_t_step    = dd_step(r_t_sr);

  always_ff @(posedge clk1M) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_edge_sr    <= 3'd0;
      r_cnt        <= '0;
      r_bit        <= 3'd0;
      r_rh_raw     <= 8'd0;
      r_t_raw      <= 8'd0;
      r_good       <= 1'b0;
      r_rh_sr      <= 20'd0;
      r_t_sr       <= 20'd0;
      r_consec     <= '0;
      rh_int       <= 8'd0;
      t_int        <= 8'd0;
      rh_bcd       <= 12'd0;
      t_bcd        <= 12'd0;
      data_valid   <= 1'b0;
      new_sample   <= 1'b0;
      crc_err      <= 1'b0;
      err_cnt      <= 8'd0;
      sensor_fault <= 1'b0;
      fan_on       <= 1'b0;
    end else begin
      r_edge_sr  <= {r_edge_sr[1:0], flag_five_sec};
      new_sample <= 1'b0;
      crc_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_edge) begin
            r_cnt   <= C_ONE;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == C_DELAY) begin
            r_rh_raw <= HYM2[39:32];
            r_t_raw  <= HYM2[23:16];
            r_good   <= w_good;
            r_state  <= S_CHECK;
            // Rejection is flagged on capture so the pulse sits in the CHECK cycle.
            if (!w_good) begin
              crc_err      <= 1'b1;
              err_cnt      <= (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
              r_consec     <= w_consec_nx;
              sensor_fault <= (w_consec_nx >= C_FAULT);
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          if (r_good) begin
            r_rh_sr <= {12'd0, r_rh_raw};
            r_t_sr  <= {12'd0, r_t_raw};
            r_bit   <= 3'd0;
            r_state <= S_BCD;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_BCD: begin
          r_rh_sr <= w_rh_step;
          r_t_sr  <= w_t_step;
          if (r_bit == 3'd7) begin
            rh_int       <= r_rh_raw;
            t_int        <= r_t_raw;
            rh_bcd       <= w_rh_step[19:8];
            t_bcd        <= w_t_step[19:8];
            data_valid   <= 1'b1;
            new_sample   <= 1'b1;
            r_consec     <= '0;
            sensor_fault <= 1'b0;
            if (r_rh_raw >= C_RH_ON)       fan_on <= 1'b1;
            else if (r_rh_raw <= C_RH_OFF) fan_on <= 1'b0;
            r_state <= S_UPDATE;
          end else begin
            r_bit <= r_bit + 3'd1;
          end
        end
        S_UPDATE: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_humidity_frame_checker.sv
// ----------------------------------------------------------------------------
// tb_humidity_frame_checker: directed and random frames against a reference model.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_humidity_frame_checker;

  localparam int SD = 20;

  logic        clk1M = 1'b0;
  logic        rst = 1'b1;
  logic        flag_five_sec = 1'b0;
  logic [39:0] HYM2 = 40'd0;
  logic [7:0]  rh_int, t_int, err_cnt;
  logic [11:0] rh_bcd, t_bcd;
  logic        data_valid, new_sample, crc_err, sensor_fault, fan_on;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_rh = 0, m_t = 0, m_valid = 0, m_err = 0, m_consec = 0, m_fan = 0;

  humidity_frame_checker #(
    .SAMPLE_DELAY(SD), .RH_ON(70), .RH_OFF(60), .FAULT_LIMIT(3)
  ) dut (
    .clk1M(clk1M), .rst(rst), .flag_five_sec(flag_five_sec), .HYM2(HYM2),
    .rh_int(rh_int), .t_int(t_int), .rh_bcd(rh_bcd), .t_bcd(t_bcd),
    .data_valid(data_valid), .new_sample(new_sample), .crc_err(crc_err),
    .err_cnt(err_cnt), .sensor_fault(sensor_fault), .fan_on(fan_on)
  );

  always #5 clk1M = ~clk1M;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [39:0] mk(input int rh, input int t);
    return {8'(rh), 8'd0, 8'(t), 8'd0, 8'((rh + t) % 256)};
  endfunction

  task automatic check_outputs();
    chk("rh_int", 40'(rh_int), 40'(m_rh));
    chk("t_int", 40'(t_int), 40'(m_t));
    chk("rh_bcd", 40'(rh_bcd), 40'(to_bcd(m_rh)));
    chk("t_bcd", 40'(t_bcd), 40'(to_bcd(m_t)));
    chk("data_valid", 40'(data_valid), 40'(m_valid));
    chk("err_cnt", 40'(err_cnt), 40'(m_err));
    chk("sensor_fault", 40'(sensor_fault), 40'(m_consec >= 3 ? 1 : 0));
    chk("fan_on", 40'(fan_on), 40'(m_fan));
  endtask

  // mode 0: plain frame; 1: extra strobe during WAIT; 2: reset pulse during BCD
  task automatic do_frame(input logic [39:0] f, input int mode);
    int ns_n, ce_n, ns_at, ce_at, lim, sum;
    bit good;
    ns_n = 0; ce_n = 0; ns_at = -1; ce_at = -1;
    lim = (mode == 1) ? 2 * (SD + 14) : SD + 14;
    @(negedge clk1M);
    HYM2 = f;
    flag_five_sec = 1'b1;
    for (int i = 1; i <= lim; i++) begin
      @(posedge clk1M); #1;
      if (new_sample) begin ns_n++; ns_at = i; end
      if (crc_err) begin ce_n++; ce_at = i; end
      if (i == 5) flag_five_sec = 1'b0;
      if (mode == 1 && i == 10) flag_five_sec = 1'b1;
      if (mode == 1 && i == 14) flag_five_sec = 1'b0;
      if (mode == 2 && i == SD + 5) rst = 1'b1;
      if (mode == 2 && i == SD + 6) rst = 1'b0;
    end
    sum = (int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8])) % 256;
    good = (sum == int'(f[7:0])) && (f != 40'd0);
    if (mode == 2) begin
      m_rh = 0; m_t = 0; m_valid = 0; m_err = 0; m_consec = 0; m_fan = 0;
      chk("rst_ns_cnt", 40'(ns_n), 40'd0);
      chk("rst_ce_cnt", 40'(ce_n), 40'd0);
    end else if (good) begin
      m_rh = int'(f[39:32]); m_t = int'(f[23:16]); m_valid = 1; m_consec = 0;
      if (m_rh >= 70) m_fan = 1;
      else if (m_rh <= 60) m_fan = 0;
      chk("ns_cnt", 40'(ns_n), 40'd1);
      chk("ns_at", 40'(ns_at), 40'(SD + 12));
      chk("ce_cnt", 40'(ce_n), 40'd0);
    end else begin
      m_err = (m_err < 255) ? m_err + 1 : 255;
      m_consec = (m_consec < 3) ? m_consec + 1 : 3;
      chk("ce_cnt", 40'(ce_n), 40'd1);
      chk("ce_at", 40'(ce_at), 40'(SD + 3));
      chk("ns_cnt", 40'(ns_n), 40'd0);
    end
    check_outputs();
  endtask

  initial begin
    int rh, t, fan_seq[5];
    logic [39:0] f;
    repeat (3) @(posedge clk1M);
    #1;
    check_outputs();
    chk("rst_new_sample", 40'(new_sample), 40'd0);
    chk("rst_crc_err", 40'(crc_err), 40'd0);
    @(negedge clk1M);
    rst = 1'b0;
    repeat (4) @(posedge clk1M);

    do_frame(40'h2D_00_17_00_44, 0);
    chk("bcd_45", 40'(rh_bcd), 40'h045);
    chk("bcd_23", 40'(t_bcd), 40'h023);
    do_frame(40'h2D_00_17_00_45, 0);
    do_frame(40'h2D_00_17_00_46, 0);
    do_frame(40'h2D_00_17_00_47, 0);
    chk("fault_after_3", 40'(sensor_fault), 40'd1);
    do_frame(mk(50, 21), 0);
    chk("fault_cleared", 40'(sensor_fault), 40'd0);
    chk("err_after_3", 40'(err_cnt), 40'd3);

    fan_seq = '{65, 72, 65, 60, 65};
    foreach (fan_seq[k]) do_frame(mk(fan_seq[k], 20), 0);
    do_frame(mk(72, 20), 0);
    do_frame(40'd0, 0);
    chk("fan_hold_zero", 40'(fan_on), 40'd1);

    do_frame(mk(33, 19), 1);
    do_frame(mk(81, 25), 2);

    for (int n = 0; n < 40; n++) begin
      rh = $urandom_range(0, 100);
      t  = $urandom_range(0, 50);
      f  = {8'(rh), 8'($urandom_range(0, 9)), 8'(t), 8'($urandom_range(0, 9)), 8'd0};
      f[7:0] = 8'((int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8])) % 256);
      if ($urandom_range(0, 3) == 0) f[7:0] = f[7:0] ^ 8'($urandom_range(1, 255));
      do_frame(f, 0);
    end

    for (int n = 0; n < 256; n++) do_frame(40'h11_00_22_00_00, 0);
    chk("err_sat", 40'(err_cnt), 40'd255);

    do_frame(40'h64_00_00_00_64, 0);
    chk("bcd_100", 40'(rh_bcd), 40'h100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
